// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline registers.
// Detects Tuse/Tnew GRF hazards and MDU-busy hazards. Drives the F/D and D/E
// register controls. Selects the F-stage PC source for interrupt entry and eret.
//
// redirect_pc is the target address that accompanies pc_sel:
//   pc_sel 1 -> HANDLER_PC
//   pc_sel 2 -> epc
//   otherwise -> 0
//
// Optional feature: define PIPE_CTRL_STATS_EN to add the stall_cnt and
// flush_cnt statistics outputs.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter logic [31:0] HANDLER_PC  = 32'h4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_use_D,
    input  logic        eret_D,
    input  logic [4:0]  WA_E,
    input  logic [4:0]  WA_M,
    input  logic        GRFWE_E,
    input  logic        GRFWE_M,
    input  logic [1:0]  Tnew_E,
    input  logic [1:0]  Tnew_M,
    input  logic        md_start_E,
    input  logic        md_div_E,
    input  logic        int_req,
    input  logic [31:0] epc,
    output logic        en_F,
    output logic        en_D,
    output logic        clr_E,
    output logic        flush_all,
    output logic [1:0]  pc_sel,
    output logic [31:0] redirect_pc,
`ifdef PIPE_CTRL_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        md_busy
);

    typedef enum logic {
        RUN = 1'b0,
        INT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] md_cnt;
    logic       stall_rs, stall_rt, stall_md, stall;
    logic       stall_applied;

    // GRF and MDU hazard detection; register 0 never creates a dependency
    always_comb begin
        stall_rs = (rs_D != 5'd0) &&
                   (((rs_D == WA_E) && GRFWE_E && (tuse_rs_D < Tnew_E)) ||
                    ((rs_D == WA_M) && GRFWE_M && (tuse_rs_D < Tnew_M)));
        stall_rt = (rt_D != 5'd0) &&
                   (((rt_D == WA_E) && GRFWE_E && (tuse_rt_D < Tnew_E)) ||
                    ((rt_D == WA_M) && GRFWE_M && (tuse_rt_D < Tnew_M)));
        md_busy  = (md_cnt != 4'd0);
        stall_md = md_use_D && (md_start_E || md_busy);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // MDU busy counter: a new start reloads, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (md_start_E)
            md_cnt <= md_div_E ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Next state and pipeline controls; priority: reset > int_req > stall > eret
    always_comb begin
        state_nxt     = state;
        en_F          = 1'b1;
        en_D          = 1'b1;
        clr_E         = 1'b0;
        flush_all     = 1'b0;
        pc_sel        = 2'd0;
        stall_applied = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (int_req) begin
                        flush_all = 1'b1;
                        pc_sel    = 2'd1;
                        state_nxt = INT;
                    end else if (stall) begin
                        en_F          = 1'b0;
                        en_D          = 1'b0;
                        clr_E         = 1'b1;
                        stall_applied = 1'b1;
                    end else if (eret_D) begin
                        pc_sel = 2'd2;
                    end
                end
                INT: begin
                    // int_req is deliberately ignored here so a held request
                    // cannot re-enter the handler on back-to-back cycles
                    state_nxt = RUN;
                    if (stall) begin
                        en_F          = 1'b0;
                        en_D          = 1'b0;
                        clr_E         = 1'b1;
                        stall_applied = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Redirect target for the F-stage PC mux
    always_comb begin
        unique case (pc_sel)
            2'd1:    redirect_pc = HANDLER_PC;
            2'd2:    redirect_pc = epc;
            default: redirect_pc = '0;
        endcase
    end

`ifdef PIPE_CTRL_STATS_EN
    // Free-running, wrapping statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_applied)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_all)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    // stall_applied only feeds the statistics counters
    logic unused_ok;
    always_comb unused_ok = stall_applied;
`endif

endmodule
